// File: rtl/instruction_encoder_if.sv
// Field-bundle input stream and imem write-beat output stream of the miniRV instruction encoder.
// The master side is the loader/imem pair; the slave side is the encoder.
interface instruction_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              r_type;
    logic              i_type;
    logic              s_type;
    logic              u_type;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_illegal;

    modport master (
        output in_valid, r_type, i_type, s_type, u_type, opcode, rd, rs1, rs2,
               funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_illegal
    );

    modport slave (
        input  in_valid, r_type, i_type, s_type, u_type, opcode, rd, rs1, rs2,
               funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_illegal
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs decoded miniRV fields into R/I/S/U instruction words and streams them as
// sequential imem write beats with an auto-incrementing word address.
module instruction_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int PROG_LEN  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    instruction_encoder_if.slave   bus,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             err_cnt
);
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  PLEN     = CNT_W'(PROG_LEN);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(PROG_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_illegal_q, out_illegal_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]  emit_cnt_q, emit_cnt_d;

    logic [3:0]        flags;
    logic              one_hot;
    logic              imm_fits12;
    logic              imm_low_zero;
    logic              enc_illegal;
    logic [31:0]       enc_word;
    logic              in_ready_w;
    logic              in_acc;
    logic              out_hs;

    // Combinational encoder: any rule violation yields a zero word flagged illegal.
    always_comb begin
        flags        = {bus.u_type, bus.s_type, bus.i_type, bus.r_type};
        one_hot      = (flags != 4'd0) && ((flags & (flags - 4'd1)) == 4'd0);
        imm_fits12   = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
        imm_low_zero = (bus.imm[11:0] == 12'd0);
        enc_word     = 32'd0;
        enc_illegal  = 1'b1;
        if (one_hot) begin
            if (bus.r_type) begin
                enc_word    = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
                enc_illegal = 1'b0;
            end else if (bus.i_type) begin
                if (imm_fits12) begin
                    enc_word    = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                    enc_illegal = 1'b0;
                end
            end else if (bus.s_type) begin
                if (imm_fits12) begin
                    enc_word    = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                                   bus.imm[4:0], bus.opcode};
                    enc_illegal = 1'b0;
                end
            end else begin
                if (imm_low_zero) begin
                    enc_word    = {bus.imm[31:12], bus.rd, bus.opcode};
                    enc_illegal = 1'b0;
                end
            end
        end
    end

    // Accept count gates in_ready so no bundle is taken beyond the program length,
    // including in the cycle where the final beat drains.
    assign in_ready_w = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready)
                        && (acc_cnt_q != PLEN);
    assign in_acc     = bus.in_valid && in_ready_w;
    assign out_hs     = out_valid_q && bus.out_ready;

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_addr_d    = out_addr_q;
        out_illegal_d = out_illegal_q;
        err_cnt_d     = err_cnt_q;
        acc_cnt_d     = acc_cnt_q;
        emit_cnt_d    = emit_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    out_addr_d = BASE;
                    emit_cnt_d = '0;
                    acc_cnt_d  = '0;
                    err_cnt_d  = 8'd0;
                end
            end
            ST_RUN: begin
                if (out_hs) begin
                    out_addr_d = out_addr_q + 1'b1;
                    emit_cnt_d = emit_cnt_q + 1'b1;
                    if (out_illegal_q && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (emit_cnt_q == LAST) begin
                        state_d = ST_DONE;
                    end
                end
                if (in_acc) begin
                    out_valid_d   = 1'b1;
                    out_instr_d   = enc_word;
                    out_illegal_d = enc_illegal;
                    acc_cnt_d     = acc_cnt_q + 1'b1;
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            out_valid_q   <= 1'b0;
            out_instr_q   <= 32'd0;
            out_addr_q    <= BASE;
            out_illegal_q <= 1'b0;
            err_cnt_q     <= 8'd0;
            acc_cnt_q     <= '0;
            emit_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_addr_q    <= out_addr_d;
            out_illegal_q <= out_illegal_d;
            err_cnt_q     <= err_cnt_d;
            acc_cnt_q     <= acc_cnt_d;
            emit_cnt_q    <= emit_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.out_illegal = out_illegal_q;
    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_DONE);
    assign err_cnt         = err_cnt_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: one DUT with an 8-bit address space and
// 4-word programs, one with a 2-bit address space, base 3 and 3-word programs.
module tb_instruction_encoder;
    logic       clk = 1'b0;
    logic       rst_a, rst_b, start_a, start_b;
    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] err_a, err_b;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    instruction_encoder_if #(.ADDR_W(8)) if_a ();
    instruction_encoder_if #(.ADDR_W(2)) if_b ();

    instruction_encoder #(.ADDR_W(8), .BASE_ADDR(0), .PROG_LEN(4)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .bus(if_a.slave),
        .busy(busy_a), .done(done_a), .err_cnt(err_a)
    );

    instruction_encoder #(.ADDR_W(2), .BASE_ADDR(3), .PROG_LEN(3)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .bus(if_b.slave),
        .busy(busy_b), .done(done_b), .err_cnt(err_b)
    );

    // Field setter; fl is {u,s,i,r}.
    task automatic set_a(input logic [3:0] fl, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        {if_a.u_type, if_a.s_type, if_a.i_type, if_a.r_type} = fl;
        if_a.opcode = op;  if_a.rd = rd;  if_a.rs1 = rs1;  if_a.rs2 = rs2;
        if_a.funct3 = f3;  if_a.funct7 = f7;  if_a.imm = imm;
    endtask

    task automatic reset_start_a();
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a   = 1'b0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    // Presents the current bundle until taken; entry and exit at posedge+1.
    task automatic accept_a();
        int n;
        if_a.in_valid = 1'b1;
        for (n = 0; n < 20 && !if_a.in_ready; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (n == 20) begin
            $display("FAIL accept_a_timeout in_ready stayed 0 required 1");
            failures++;
        end
        @(posedge clk); #1;
        if_a.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;  rst_b = 1'b1;  start_a = 1'b0;  start_b = 1'b0;
        if_a.in_valid = 1'b0;  if_a.out_ready = 1'b0;
        set_a(4'b0000, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        if_b.in_valid = 1'b0;  if_b.out_ready = 1'b0;
        {if_b.u_type, if_b.s_type, if_b.i_type, if_b.r_type} = 4'b0010;
        if_b.opcode = 7'h13;  if_b.rd = 5'd1;  if_b.rs1 = 5'd0;  if_b.rs2 = 5'd0;
        if_b.funct3 = 3'd0;  if_b.funct7 = 7'd0;  if_b.imm = 32'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        checks++; if (if_a.out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b exp=0", if_a.out_valid); failures++; end
        checks++; if (if_a.out_instr !== 32'd0) begin $display("FAIL reset_out_instr got=%h exp=0", if_a.out_instr); failures++; end
        checks++; if (if_a.out_addr !== 8'd0) begin $display("FAIL reset_out_addr got=%0d exp=0", if_a.out_addr); failures++; end
        checks++; if ({if_a.out_illegal, busy_a, done_a, if_a.in_ready} !== 4'b0000) begin
            $display("FAIL reset_flags got=%b exp=0000", {if_a.out_illegal, busy_a, done_a, if_a.in_ready}); failures++; end
        checks++; if (err_a !== 8'd0) begin $display("FAIL reset_err_cnt got=%0d exp=0", err_a); failures++; end
        checks++; if (if_b.out_addr !== 2'd3) begin $display("FAIL reset_b_out_addr got=%0d exp=3", if_b.out_addr); failures++; end
    endtask

    task automatic test_itype();
        reset_start_a();
        if_a.out_ready = 1'b0;
        set_a(4'b0010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        accept_a();
        $display("beat I addr=%0d instr=%h ill=%b", if_a.out_addr, if_a.out_instr, if_a.out_illegal);
        checks++; if (if_a.out_valid !== 1'b1 || if_a.out_instr !== 32'hFFF0_0093) begin
            $display("FAIL itype_word got=%b/%h exp=1/fff00093", if_a.out_valid, if_a.out_instr); failures++; end
        checks++; if (if_a.out_addr !== 8'd0 || if_a.out_illegal !== 1'b0) begin
            $display("FAIL itype_addr_ill got=%0d/%b exp=0/0", if_a.out_addr, if_a.out_illegal); failures++; end
        @(posedge clk); #1;
        checks++; if (if_a.out_valid !== 1'b1 || if_a.out_instr !== 32'hFFF0_0093 || if_a.in_ready !== 1'b0) begin
            $display("FAIL itype_stall_hold got=%b/%h/%b exp=1/fff00093/0", if_a.out_valid, if_a.out_instr, if_a.in_ready); failures++; end
        if_a.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (if_a.out_valid !== 1'b0 || if_a.out_addr !== 8'd1) begin
            $display("FAIL itype_drain got=%b/%0d exp=0/1", if_a.out_valid, if_a.out_addr); failures++; end
    endtask

    task automatic test_stype();
        reset_start_a();
        if_a.out_ready = 1'b1;
        set_a(4'b0100, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'h0000_07FC);
        accept_a();
        $display("beat S addr=%0d instr=%h ill=%b", if_a.out_addr, if_a.out_instr, if_a.out_illegal);
        checks++; if (if_a.out_instr !== 32'h7E51_2E23 || if_a.out_illegal !== 1'b0) begin
            $display("FAIL stype_word got=%h/%b exp=7e512e23/0", if_a.out_instr, if_a.out_illegal); failures++; end
        if_a.imm = 32'h0000_0800;
        accept_a();
        $display("beat S addr=%0d instr=%h ill=%b", if_a.out_addr, if_a.out_instr, if_a.out_illegal);
        checks++; if (if_a.out_instr !== 32'd0 || if_a.out_illegal !== 1'b1 || if_a.out_addr !== 8'd1) begin
            $display("FAIL stype_range got=%h/%b/%0d exp=0/1/1", if_a.out_instr, if_a.out_illegal, if_a.out_addr); failures++; end
        checks++; if (err_a !== 8'd0) begin $display("FAIL stype_err_before got=%0d exp=0", err_a); failures++; end
        @(posedge clk); #1;
        checks++; if (err_a !== 8'd1 || if_a.out_valid !== 1'b0) begin
            $display("FAIL stype_err_cnt got=%0d/%b exp=1/0", err_a, if_a.out_valid); failures++; end
    endtask

    task automatic test_utype();
        reset_start_a();
        if_a.out_ready = 1'b1;
        set_a(4'b1000, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        accept_a();
        $display("beat U addr=%0d instr=%h ill=%b", if_a.out_addr, if_a.out_instr, if_a.out_illegal);
        checks++; if (if_a.out_instr !== 32'h1234_51B7 || if_a.out_illegal !== 1'b0) begin
            $display("FAIL utype_word got=%h/%b exp=123451b7/0", if_a.out_instr, if_a.out_illegal); failures++; end
        if_a.imm = 32'h1234_5001;
        accept_a();
        $display("beat U addr=%0d instr=%h ill=%b", if_a.out_addr, if_a.out_instr, if_a.out_illegal);
        checks++; if (if_a.out_instr !== 32'd0 || if_a.out_illegal !== 1'b1) begin
            $display("FAIL utype_low_bits got=%h/%b exp=0/1", if_a.out_instr, if_a.out_illegal); failures++; end
    endtask

    task automatic test_rtype();
        reset_start_a();
        if_a.out_ready = 1'b1;
        set_a(4'b0011, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        accept_a();
        $display("beat R addr=%0d instr=%h ill=%b", if_a.out_addr, if_a.out_instr, if_a.out_illegal);
        checks++; if (if_a.out_instr !== 32'd0 || if_a.out_illegal !== 1'b1) begin
            $display("FAIL rtype_two_flags got=%h/%b exp=0/1", if_a.out_instr, if_a.out_illegal); failures++; end
        if_a.i_type = 1'b0;
        accept_a();
        $display("beat R addr=%0d instr=%h ill=%b", if_a.out_addr, if_a.out_instr, if_a.out_illegal);
        checks++; if (if_a.out_instr !== 32'h0020_81B3 || if_a.out_illegal !== 1'b0) begin
            $display("FAIL rtype_word got=%h/%b exp=002081b3/0", if_a.out_instr, if_a.out_illegal); failures++; end
        @(posedge clk); #1;
        checks++; if (err_a !== 8'd1 || if_a.out_addr !== 8'd2) begin
            $display("FAIL rtype_err_addr got=%0d/%0d exp=1/2", err_a, if_a.out_addr); failures++; end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_word [4];
        int sent = 0;
        int recv = 0;
        exp_word[0] = 32'h0000_0093;  exp_word[1] = 32'h0010_0113;
        exp_word[2] = 32'h0020_0193;  exp_word[3] = 32'h0030_0213;
        reset_start_a();
        for (int cyc = 0; cyc < 100 && recv < 4; cyc++) begin
            if_a.out_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            set_a(4'b0010, 7'h13, 5'(sent + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent));
            if_a.in_valid = (sent < 4);
            #1;
            if (if_a.out_valid && if_a.out_ready) begin
                $display("beat stream addr=%0d instr=%h", if_a.out_addr, if_a.out_instr);
                checks++; if (if_a.out_addr !== 8'(recv) || if_a.out_instr !== exp_word[recv]) begin
                    $display("FAIL stream_beat%0d got=%0d/%h exp=%0d/%h", recv, if_a.out_addr, if_a.out_instr, recv, exp_word[recv]); failures++; end
                recv++;
            end
            if (if_a.in_valid && if_a.in_ready) sent++;
            @(posedge clk); #1;
        end
        if_a.in_valid  = 1'b0;
        if_a.out_ready = 1'b1;
        checks++; if (recv != 4) begin $display("FAIL stream_count got=%0d exp=4", recv); failures++; end
        checks++; if ({done_a, busy_a, if_a.out_valid, if_a.in_ready} !== 4'b1000 || if_a.out_addr !== 8'd4) begin
            $display("FAIL stream_done got=%b/%0d exp=1000/4", {done_a, busy_a, if_a.out_valid, if_a.in_ready}, if_a.out_addr); failures++; end
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++; if (busy_a !== 1'b1 || if_a.out_addr !== 8'd0 || err_a !== 8'd0) begin
            $display("FAIL restart got=%b/%0d/%0d exp=1/0/0", busy_a, if_a.out_addr, err_a); failures++; end
    endtask

    task automatic test_wrap_and_reset();
        logic [1:0] exp_addr [3];
        int sent = 0;
        int recv = 0;
        exp_addr[0] = 2'd3;  exp_addr[1] = 2'd0;  exp_addr[2] = 2'd1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        if_b.out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && recv < 3; cyc++) begin
            if_b.in_valid = (sent < 3);
            #1;
            if (if_b.out_valid && if_b.out_ready) begin
                $display("beat wrap addr=%0d instr=%h", if_b.out_addr, if_b.out_instr);
                checks++; if (if_b.out_addr !== exp_addr[recv] || if_b.out_instr !== 32'h0050_0093) begin
                    $display("FAIL wrap_beat%0d got=%0d/%h exp=%0d/00500093", recv, if_b.out_addr, if_b.out_instr, exp_addr[recv]); failures++; end
                recv++;
            end
            if (if_b.in_valid && if_b.in_ready) sent++;
            @(posedge clk); #1;
        end
        if_b.in_valid = 1'b0;
        checks++; if (recv != 3 || done_b !== 1'b1 || if_b.out_addr !== 2'd2) begin
            $display("FAIL wrap_done got=%0d/%b/%0d exp=3/1/2", recv, done_b, if_b.out_addr); failures++; end
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        if_b.out_ready = 1'b0;
        if_b.in_valid  = 1'b1;
        @(posedge clk); #1;
        if_b.in_valid = 1'b0;
        checks++; if (if_b.out_valid !== 1'b1 || if_b.out_addr !== 2'd3) begin
            $display("FAIL stall_before_rst got=%b/%0d exp=1/3", if_b.out_valid, if_b.out_addr); failures++; end
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        checks++; if ({if_b.out_valid, busy_b, done_b, if_b.in_ready} !== 4'b0000 || if_b.out_addr !== 2'd3) begin
            $display("FAIL rst_mid_transfer got=%b/%0d exp=0000/3", {if_b.out_valid, busy_b, done_b, if_b.in_ready}, if_b.out_addr); failures++; end
    endtask

    initial begin
        #1;
        test_reset();
        test_itype();
        test_stype();
        test_utype();
        test_rtype();
        test_back_to_back();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
